// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard controller for a 5-stage MIPS pipeline: operand bypass
// selection, load-use and HI/LO hazard detection, mult/div busy tracking and a stall counter.
module fwd_hazard_ctrl #(
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int NSTG  = 3,
    parameter int MDLAT = 4,
    parameter int CW    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NRD*AW-1:0]            ex_src,
    input  logic [NSTG-1:0]              stg_we,
    input  logic [NSTG*AW-1:0]           stg_rd,
    output logic [NRD*$clog2(NSTG+1)-1:0] fwd_sel,
    input  logic [NRD*AW-1:0]            id_src,
    input  logic [NRD-1:0]               id_src_vld,
    input  logic                         ex_is_load,
    input  logic [AW-1:0]                ex_rd,
    input  logic                         id_md_issue,
    input  logic                         id_hilo_rd,
    input  logic                         flush_in,
    input  logic                         perf_clr,
    output logic                         stall_if_id,
    output logic                         flush_id_ex,
    output logic                         md_busy,
    output logic                         md_done,
    output logic [CW-1:0]                stall_cnt
);

    localparam int SW   = $clog2(NSTG + 1);
    localparam int CNTW = (MDLAT > 1) ? $clog2(MDLAT) : 1;
    localparam logic [CNTW-1:0] MD_LOAD   = CNTW'(MDLAT - 1);
    localparam logic [CW-1:0]   STALL_MAX = '1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t       r_state;
    md_state_t       w_state_next;
    logic [CNTW-1:0] r_md_cnt;
    logic [CNTW-1:0] w_md_cnt_next;
    logic [CW-1:0]   r_stall_cnt;

    logic w_lu_match;
    logic w_lu;
    logic w_md_busy;
    logic w_md_haz;
    logic w_stall;
    logic w_md_start;

    // Scanning farthest-to-nearest lets the nearest matching stage overwrite the select last.
    // NOTE: every signal driven in always_comb gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (stg_we[k] && (ex_src[i*AW +: AW] != '0) &&
                    (stg_rd[k*AW +: AW] == ex_src[i*AW +: AW])) begin
                    fwd_sel[i*SW +: SW] = SW'(k + 1);
                end
            end
        end
    end

    always_comb begin
        w_lu_match = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (id_src_vld[i] && (id_src[i*AW +: AW] == ex_rd)) begin
                w_lu_match = 1'b1;
            end
        end
    end

    assign w_lu      = ex_is_load && (ex_rd != '0) && w_lu_match;
    assign w_md_busy = (r_state != MD_IDLE);
    assign w_md_haz  = w_md_busy && (id_hilo_rd || id_md_issue);

    // Gating with rst_n keeps the pipeline controls quiet while reset is held, even if
    // the hazard inputs are active.
    assign w_stall    = rst_n && (w_lu || w_md_haz) && !flush_in;
    assign w_md_start = id_md_issue && !w_stall && !flush_in;

    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            MD_IDLE: begin
                if (w_md_start) begin
                    w_state_next  = MD_BUSY;
                    w_md_cnt_next = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_md_cnt == '0) begin
                    w_state_next = MD_DONE;
                end else begin
                    w_md_cnt_next = r_md_cnt - 1'b1;
                end
            end
            MD_DONE: begin
                w_state_next = MD_IDLE;
            end
            default: begin
                w_state_next  = MD_IDLE;
                w_md_cnt_next = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order across always blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MD_IDLE;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_if_id = w_stall;
    assign flush_id_ex = w_stall;
    assign md_busy     = w_md_busy;
    assign md_done     = (r_state == MD_DONE);
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: a cycle-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_fwd_hazard_ctrl;

    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NSTG  = 3;
    localparam int MDLAT = 4;
    localparam int CW    = 4;
    localparam int SW    = $clog2(NSTG + 1);
    localparam int SMAX  = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NRD*AW-1:0]    ex_src = '0;
    logic [NSTG-1:0]      stg_we = '0;
    logic [NSTG*AW-1:0]   stg_rd = '0;
    logic [NRD*SW-1:0]    fwd_sel;
    logic [NRD*AW-1:0]    id_src = '0;
    logic [NRD-1:0]       id_src_vld = '0;
    logic                 ex_is_load = 1'b0;
    logic [AW-1:0]        ex_rd = '0;
    logic                 id_md_issue = 1'b0;
    logic                 id_hilo_rd = 1'b0;
    logic                 flush_in = 1'b0;
    logic                 perf_clr = 1'b0;
    logic                 stall_if_id;
    logic                 flush_id_ex;
    logic                 md_busy;
    logic                 md_done;
    logic [CW-1:0]        stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_ctrl #(
        .AW(AW), .NRD(NRD), .NSTG(NSTG), .MDLAT(MDLAT), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_src     (ex_src),
        .stg_we     (stg_we),
        .stg_rd     (stg_rd),
        .fwd_sel    (fwd_sel),
        .id_src     (id_src),
        .id_src_vld (id_src_vld),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_md_issue(id_md_issue),
        .id_hilo_rd (id_hilo_rd),
        .flush_in   (flush_in),
        .perf_clr   (perf_clr),
        .stall_if_id(stall_if_id),
        .flush_id_ex(flush_id_ex),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // md_left counts cycles until the mult/div unit is idle again; stalls are counted as an int.
    int m_md_left   = 0;
    int m_stall_cnt = 0;

    function automatic int model_fwd(input int op);
        int src;
        src = int'(ex_src[op*AW +: AW]);
        if (src == 0) return 0;
        for (int k = 0; k < NSTG; k++)
            if (stg_we[k] && int'(stg_rd[k*AW +: AW]) == src) return k + 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        bit lu;
        bit haz;
        lu = 1'b0;
        if (ex_is_load && ex_rd != 0)
            for (int i = 0; i < NRD; i++)
                if (id_src_vld[i] && id_src[i*AW +: AW] == ex_rd) lu = 1'b1;
        haz = (m_md_left > 0) && (id_hilo_rd || id_md_issue);
        return rst_n && (lu || haz) && !flush_in;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_md_left   = 0;
            m_stall_cnt = 0;
        end else begin
            bit st;
            st = model_stall();
            if (perf_clr) m_stall_cnt = 0;
            else if (st && m_stall_cnt < SMAX) m_stall_cnt = m_stall_cnt + 1;
            if (m_md_left > 0) m_md_left = m_md_left - 1;
            else if (id_md_issue && !st && !flush_in) m_md_left = MDLAT + 1;
        end
    end

    // One compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NRD; i++)
            check($sformatf("model fwd_sel op%0d", i), int'(fwd_sel[i*SW +: SW]), model_fwd(i));
        check("model stall_if_id", int'(stall_if_id), int'(model_stall()));
        check("model flush_id_ex", int'(flush_id_ex), int'(model_stall()));
        check("model md_busy", int'(md_busy), int'(m_md_left > 0));
        check("model md_done", int'(md_done), int'(m_md_left == 1));
        check("model stall_cnt", int'(stall_cnt), m_stall_cnt);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_src = '0; stg_we = '0; stg_rd = '0; id_src = '0; id_src_vld = '0;
        ex_is_load = 1'b0; ex_rd = '0; id_md_issue = 1'b0; id_hilo_rd = 1'b0;
        flush_in = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_rd = 5'd9;
        id_src[1*AW +: AW] = 5'd9; id_src_vld = 2'b10;
    endtask

    initial begin
        // Reset state, with a would-be load-use present to show stall is held low.
        set_load_use();
        step(2);
        check("reset stall_if_id", int'(stall_if_id), 0);
        check("reset md_busy", int'(md_busy), 0);
        check("reset stall_cnt", int'(stall_cnt), 0);
        clear_inputs();
        rst_n = 1'b1;
        step(1);

        // T1: all three stages write r5; nearest wins, then farther ones as they drop out.
        ex_src[0 +: AW] = 5'd5;
        stg_we = 3'b111;
        stg_rd = {5'd5, 5'd5, 5'd5};
        #1 check("T1 op0 all match", int'(fwd_sel[0 +: SW]), 1);
        stg_we = 3'b110;
        #1 check("T1 op0 mem/wb", int'(fwd_sel[0 +: SW]), 2);
        stg_we = 3'b100;
        #1 check("T1 op0 wb", int'(fwd_sel[0 +: SW]), 3);
        stg_we = 3'b000;
        #1 check("T1 op0 no write", int'(fwd_sel[0 +: SW]), 0);
        step(1);

        // T2: op0 reads r0, op1 reads r7; stage 1 writes r0 then r7.
        clear_inputs();
        ex_src = {5'd7, 5'd0};
        stg_we = 3'b010;
        stg_rd[1*AW +: AW] = 5'd0;
        #1 check("T2 op0 rd0", int'(fwd_sel[0 +: SW]), 0);
        check("T2 op1 rd0", int'(fwd_sel[SW +: SW]), 0);
        stg_rd[1*AW +: AW] = 5'd7;
        #1 check("T2 op0 rd7", int'(fwd_sel[0 +: SW]), 0);
        check("T2 op1 rd7", int'(fwd_sel[SW +: SW]), 2);
        step(1);

        // T3: load-use only when the operand is really read.
        clear_inputs();
        set_load_use();
        id_src_vld = 2'b00;
        #1 check("T3 not read", int'(stall_if_id), 0);
        id_src_vld = 2'b10;
        #1 check("T3 read stall", int'(stall_if_id), 1);
        check("T3 bubble", int'(flush_id_ex), 1);
        step(1);
        clear_inputs();
        #1 check("T3 stall_cnt", int'(stall_cnt), 1);
        step(1);

        // T4: mult issue, mfhi right behind it.
        id_md_issue = 1'b1;
        step(1);
        id_md_issue = 1'b0;
        id_hilo_rd  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("T4 stall c%0d", i + 1), int'(stall_if_id), 1);
            check($sformatf("T4 md_done c%0d", i + 1), int'(md_done), int'(i == 4));
            step(1);
        end
        check("T4 mfhi proceeds", int'(stall_if_id), 0);
        check("T4 md idle", int'(md_busy), 0);
        check("T4 stall_cnt", int'(stall_cnt), 6);
        id_hilo_rd = 1'b0;
        step(1);

        // T5: flush overrides load-use and mult/div issue.
        set_load_use();
        flush_in = 1'b1;
        #1 check("T5 flush beats lu", int'(stall_if_id), 0);
        step(1);
        check("T5 no count", int'(stall_cnt), 6);
        clear_inputs();
        id_md_issue = 1'b1;
        flush_in    = 1'b1;
        step(1);
        check("T5 no issue", int'(md_busy), 0);
        clear_inputs();
        step(1);

        // T6: saturation, clear-beats-stall, reset aborting a busy op.
        set_load_use();
        step(20);
        check("T6 saturate", int'(stall_cnt), SMAX);
        perf_clr = 1'b1;
        step(1);
        check("T6 clear with stall", int'(stall_cnt), 0);
        clear_inputs();
        id_md_issue = 1'b1;
        step(1);
        id_md_issue = 1'b0;
        step(1);
        check("T6 busy before reset", int'(md_busy), 1);
        rst_n = 1'b0;
        #1 check("T6 reset md_busy", int'(md_busy), 0);
        check("T6 reset md_done", int'(md_done), 0);
        step(1);
        rst_n = 1'b1;
        step(MDLAT + 2);
        check("T6 aborted op silent", int'(md_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
